// File: rtl/noc_tx_arbiter.sv
// noc_tx_arbiter
//   Shares the NoC router local injection port among NUM_REQ requesters.
//   A winner's flit is latched in IDLE and offered to the router in ISSUE.
//   The flit stays in ISSUE until the router takes it (noc_wr_o=1 and
//   noc_wait_i=0). Sustained rate is at most one flit every two cycles.
//
//   Optional feature: define NOC_TX_ARB_FIXED_PRIO_EN for fixed priority
//   (the lowest set index wins, and no last-grant state is kept). When it
//   is undefined, arbitration is round-robin starting after the last
//   accepted index.
//
// Ports
//   clk_i      : clock; all state changes on the rising edge
//   rst_n_i    : asynchronous active-low reset
//   req_i      : per-requester flit-pending request
//   data_i     : requester k flit at [k*NOC_BUS_SIZE +: NOC_BUS_SIZE]
//   ack_o      : one-hot strobe, combinational, high on the acceptance cycle
//   grant_o    : index of the current or last granted requester
//   busy_o     : high while a flit is offered (ISSUE)
//   noc_din_o  : flit to the router
//   noc_wr_o   : write strobe to the router (ISSUE)
//   noc_wait_i : router backpressure
module noc_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_REQ_LOG2 = 2,
  parameter int NOC_BUS_SIZE = 66
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*NOC_BUS_SIZE-1:0] data_i,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic [NUM_REQ_LOG2-1:0]         grant_o,
  output logic                            busy_o,
  output logic [NOC_BUS_SIZE-1:0]         noc_din_o,
  output logic                            noc_wr_o,
  input  logic                            noc_wait_i
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e                    state_q;
  logic [NOC_BUS_SIZE-1:0]   din_q;
  logic [NUM_REQ_LOG2-1:0]   grant_q;
  logic [NUM_REQ_LOG2-1:0]   win_d;

`ifdef NOC_TX_ARB_FIXED_PRIO_EN
  // Scan from the top so that the lowest set index is written last.
  always_comb begin
    win_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[NUM_REQ_LOG2'(k)]) win_d = NUM_REQ_LOG2'(k);
    end
  end
`else
  logic [NUM_REQ_LOG2-1:0] last_q;
  logic [NUM_REQ_LOG2-1:0] idx_d;
  logic                    found_d;
  int                      pos_d;

  // Search last_q+1, last_q+2, ... and wrap, so the requester that was
  // served last has the lowest priority this round.
  always_comb begin
    win_d   = last_q;
    idx_d   = '0;
    found_d = 1'b0;
    pos_d   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos_d = int'(last_q) + off;
      if (pos_d >= NUM_REQ) pos_d = pos_d - NUM_REQ;
      idx_d = NUM_REQ_LOG2'(pos_d);
      if (!found_d && req_i[idx_d]) begin
        win_d   = idx_d;
        found_d = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      din_q   <= '0;
      grant_q <= '0;
`ifndef NOC_TX_ARB_FIXED_PRIO_EN
      last_q  <= NUM_REQ_LOG2'(NUM_REQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // With no request, the flit and grant registers hold their values.
          if (|req_i) begin
            din_q   <= data_i[win_d*NOC_BUS_SIZE +: NOC_BUS_SIZE];
            grant_q <= win_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!noc_wait_i) begin
            state_q <= IDLE;
`ifndef NOC_TX_ARB_FIXED_PRIO_EN
            last_q  <= grant_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The strobe is combinational so that the requester sees it in the same
  // cycle as the router accepts the flit. It can then drop req_i on that edge.
  always_comb begin
    ack_o = '0;
    if (state_q == ISSUE && !noc_wait_i) ack_o[grant_q] = 1'b1;
  end

  assign busy_o    = (state_q == ISSUE);
  assign noc_wr_o  = (state_q == ISSUE);
  assign noc_din_o = din_q;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
module tb_noc_tx_arbiter;
  localparam int NR = 4;
  localparam int NL = 2;
  localparam int NB = 66;

  typedef struct {
    logic [NL-1:0] g;
    logic [NB-1:0] d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NB-1:0]     dat [NR];
  logic [NR*NB-1:0]  data;
  logic [NR-1:0]     ack;
  logic [NL-1:0]     grant;
  logic              busy;
  logic [NB-1:0]     din;
  logic              wr;
  logic              nwait = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];

  assign data = {dat[3], dat[2], dat[1], dat[0]};

  noc_tx_arbiter #(.NUM_REQ(NR), .NUM_REQ_LOG2(NL), .NOC_BUS_SIZE(NB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data),
    .ack_o(ack), .grant_o(grant), .busy_o(busy), .noc_din_o(din),
    .noc_wr_o(wr), .noc_wait_i(nwait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic drv_slot();
    @(posedge clk); #1;
  endtask

  function automatic exp_t mk(input logic [NL-1:0] g, input logic [NB-1:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    return e;
  endfunction

  // Scoreboard: each acceptance must match the next queued (grant, flit).
  always @(negedge clk) begin
    if (rst_n && (|ack)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {124'd0, ack}, 128'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_grant", {126'd0, grant}, {126'd0, e.g});
        chk("sb_flit", {62'd0, din}, {62'd0, e.d});
        chk("sb_ack_onehot", {124'd0, ack}, {124'd0, 4'b0001 << e.g});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NB-1:0] held;
    dat[0] = 66'h155;
    dat[1] = 66'h2_0000_0000_0000_0A11;
    dat[2] = 66'h1_2345_6789_ABCD_EF01;
    dat[3] = 66'h3_FFFF_0000_FFFF_0033;

    // Reset state
    @(negedge clk);
    chk("rst_wr", {127'd0, wr}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ack", {124'd0, ack}, 128'd0);
    chk("rst_din", {62'd0, din}, 128'd0);
    chk("rst_grant", {126'd0, grant}, 128'd0);
    #2 rst_n = 1'b1;

    // Single flit from requester 0
    drv_slot(); req = 4'b0001; exp_q.push_back(mk(2'd0, 66'h155));
    @(negedge clk);
    chk("c0_wr", {127'd0, wr}, 128'd0);
    @(negedge clk);
    chk("c1_wr", {127'd0, wr}, 128'd1);
    chk("c1_din", {62'd0, din}, 128'h155);
    chk("c1_ack", {124'd0, ack}, 128'b0001);
    drv_slot(); req = 4'b0000;
    @(negedge clk);
    chk("c2_busy", {127'd0, busy}, 128'd0);
    repeat (2) @(negedge clk);

    // Reset, so that arbitration starts from a known point
    drv_slot(); rst_n = 1'b0;
    #2 rst_n = 1'b1;

`ifdef NOC_TX_ARB_FIXED_PRIO_EN
    // With fixed priority, requester 1 always wins and requester 3 starves
    drv_slot(); req = 4'b1010;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(2'd1, dat[1]));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        chk("fp_ack", {124'd0, ack}, 128'b0010);
        chk("fp_grant", {126'd0, grant}, 128'd1);
      end else begin
        chk("fp_ack_gap", {124'd0, ack}, 128'd0);
      end
    end
    drv_slot(); req = 4'b0000;
`else
    // Round-robin with all requesters held
    begin
      logic [NL-1:0] seq [5];
      seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
      drv_slot(); req = 4'b1111;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(seq[i], dat[seq[i]]));
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (i % 2 == 1) chk("rr_ack", {124'd0, ack}, {124'd0, 4'b0001 << seq[i/2]});
        else chk("rr_ack_gap", {124'd0, ack}, 128'd0);
      end
      drv_slot(); req = 4'b0000;
    end
`endif
    repeat (2) @(negedge clk);

    // Router backpressure for 5 cycles
    drv_slot(); req = 4'b0010; nwait = 1'b1; exp_q.push_back(mk(2'd1, dat[1]));
    @(negedge clk); @(negedge clk);
    chk("st_wr", {127'd0, wr}, 128'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("st_din", {62'd0, din}, {62'd0, dat[1]});
      chk("st_grant", {126'd0, grant}, 128'd1);
      chk("st_ack", {124'd0, ack}, 128'd0);
    end
    drv_slot(); nwait = 1'b0;
    @(negedge clk);
    chk("st_release_ack", {124'd0, ack}, 128'b0010);
    drv_slot(); req = 4'b0000;
    @(negedge clk);
    chk("st_idle", {127'd0, busy}, 128'd0);

    // Requester 2 drops req_i mid-ISSUE. The latched flit must still be delivered.
    held = dat[2];
    drv_slot(); req = 4'b0100; nwait = 1'b1; exp_q.push_back(mk(2'd2, held));
    @(negedge clk); @(negedge clk);
    chk("dr_grant", {126'd0, grant}, 128'd2);
    drv_slot(); req = 4'b0000; dat[2] = ~held;
    @(negedge clk);
    chk("dr_din_latched", {62'd0, din}, {62'd0, held});
    drv_slot(); nwait = 1'b0;
    @(negedge clk);
    chk("dr_ack", {124'd0, ack}, 128'b0100);
    dat[2] = held;

    // Idle with no request: the flit and grant hold
    repeat (3) @(negedge clk);
    chk("hold_din", {62'd0, din}, {62'd0, held});
    chk("hold_grant", {126'd0, grant}, 128'd2);
    chk("hold_busy", {127'd0, busy}, 128'd0);

    // Asynchronous reset in the middle of ISSUE: the flit is abandoned
    drv_slot(); req = 4'b1000; nwait = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ar_wr_before", {127'd0, wr}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wr", {127'd0, wr}, 128'd0);
    chk("ar_busy", {127'd0, busy}, 128'd0);
    chk("ar_ack", {124'd0, ack}, 128'd0);
    chk("ar_grant", {126'd0, grant}, 128'd0);
    chk("ar_din", {62'd0, din}, 128'd0);
    drv_slot(); rst_n = 1'b1; nwait = 1'b0; exp_q.push_back(mk(2'd3, dat[3]));
    @(negedge clk); @(negedge clk);
    chk("ar_rereq_ack", {124'd0, ack}, 128'b1000);
    drv_slot(); req = 4'b0000;
    repeat (3) @(negedge clk);

    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
